// File: rtl/rf_wb_sched.sv
// Write-port scheduler and pending-long-op scoreboard for a single-write-port register file.
// Optional protocol checker enabled by defining RF_SCHED_CHECK_EN (DEBUG adds messages).
module rf_wb_sched #(
  parameter int unsigned LQ_DEPTH = 2,
  parameter int unsigned MAX_LONG = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_ra_i,
  input  logic [4:0]  id_rb_i,
  input  logic [4:0]  id_rw_i,
  input  logic        id_wen_i,
  input  logic        id_long_i,
  output logic        stall_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rw_i,
  input  logic [31:0] wb_data_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_rw_i,
  input  logic [31:0] lu_data_i,
  output logic        lu_ready_o,
  output logic        rf_regwr_o,
  output logic [4:0]  rf_rw_o,
  output logic [31:0] rf_busw_o,
  output logic [31:0] busy_mask_o,
  output logic        sched_err_o
);

  localparam int unsigned RW_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned OCC_W  = $clog2(LQ_DEPTH + 1);
  localparam int unsigned CNT_W  = $clog2(MAX_LONG + 1);

  typedef struct packed {
    logic [RW_W-1:0]   rw;
    logic [DATA_W-1:0] data;
  } lq_entry_t;

  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  lq_entry_t        lq_mem_q [LQ_DEPTH];
  lq_entry_t        head;

  logic fifo_full, fifo_empty;
  logic raw, waw, cap;
  logic lu_acc, enq, deq, bypass, commit, issue;
  logic [RW_W-1:0] commit_rw;

  assign fifo_full  = (occ_q == OCC_W'(LQ_DEPTH));
  assign fifo_empty = (occ_q == '0);
  assign head       = lq_mem_q[rd_ptr_q];

  // Hazards against registers still owed a long-op result
  assign raw = ((id_ra_i != '0) && busy_q[id_ra_i]) || ((id_rb_i != '0) && busy_q[id_rb_i]);
  assign waw = id_wen_i && (id_rw_i != '0) && busy_q[id_rw_i];
  assign cap = id_long_i && (count_q == CNT_W'(MAX_LONG));

  assign stall_o    = rst || (id_valid_i && (raw || waw || cap || fifo_full));
  assign lu_ready_o = !fifo_full && !rst;
  assign lu_acc     = lu_valid_i && lu_ready_o;
  assign issue      = id_valid_i && id_long_i && !stall_o;

  // WB owns the port; otherwise the oldest queued result; otherwise bypass a fresh one
  assign deq    = !rst && !wb_valid_i && !fifo_empty;
  assign bypass = !rst && !wb_valid_i && fifo_empty && lu_acc;
  assign enq    = lu_acc && !bypass;
  assign commit = deq || bypass;

  always_comb begin
    rf_regwr_o = 1'b0;
    rf_rw_o    = '0;
    rf_busw_o  = '0;
    commit_rw  = '0;
    if (!rst && wb_valid_i) begin
      rf_regwr_o = 1'b1;
      rf_rw_o    = wb_rw_i;
      rf_busw_o  = wb_data_i;
    end else if (deq) begin
      rf_regwr_o = 1'b1;
      rf_rw_o    = head.rw;
      rf_busw_o  = head.data;
      commit_rw  = head.rw;
    end else if (bypass) begin
      rf_regwr_o = 1'b1;
      rf_rw_o    = lu_rw_i;
      rf_busw_o  = lu_data_i;
      commit_rw  = lu_rw_i;
    end
  end

  // Scoreboard and FIFO bookkeeping; issue and commit never touch the same bit
  always_comb begin
    busy_d = busy_q;
    if (commit) busy_d[commit_rw] = 1'b0;
    if (issue && id_wen_i && (id_rw_i != '0)) busy_d[id_rw_i] = 1'b1;
    busy_d[0] = 1'b0;
    count_d  = count_q + CNT_W'(issue) - CNT_W'(commit);
    occ_d    = occ_q + OCC_W'(enq) - OCC_W'(deq);
    wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      count_q  <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      busy_q   <= busy_d;
      count_q  <= count_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) lq_mem_q[wr_ptr_q] <= '{rw: lu_rw_i, data: lu_data_i};
  end

  assign busy_mask_o = busy_q;

`ifdef RF_SCHED_CHECK_EN
  logic err_wb, err_lu_idle, err_lu_cnt, err_any;
  logic sched_err_q, sched_err_d;

  assign err_wb      = !rst && wb_valid_i && (wb_rw_i != '0) && busy_q[wb_rw_i];
  assign err_lu_idle = lu_acc && (lu_rw_i != '0) && !busy_q[lu_rw_i];
  assign err_lu_cnt  = lu_acc && (count_q == '0);
  assign err_any     = err_wb || err_lu_idle || err_lu_cnt;

  always_comb begin
    sched_err_d = sched_err_q;
    if (err_any) sched_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sched_err_q <= 1'b0;
    else     sched_err_q <= sched_err_d;
  end

`ifdef DEBUG
  always_ff @(posedge clk) begin
    if (err_wb)      $display("rf_wb_sched: WB write to pending r%0d", wb_rw_i);
    if (err_lu_idle) $display("rf_wb_sched: LU result for idle r%0d", lu_rw_i);
    if (err_lu_cnt)  $display("rf_wb_sched: LU result r%0d with no long op outstanding", lu_rw_i);
  end
`endif

  assign sched_err_o = sched_err_q;
`else
  assign sched_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_sched.sv
// Bench for rf_wb_sched: directed scenarios then random legal traffic against a queue-based model.
module tb_rf_wb_sched;
  localparam int LQ_DEPTH = 2;
  localparam int MAX_LONG = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 0, id_wen = 0, id_long = 0;
  logic [4:0] id_ra = 0, id_rb = 0, id_rw = 0;
  logic wb_valid = 0, lu_valid = 0;
  logic [4:0] wb_rw = 0, lu_rw = 0;
  logic [31:0] wb_data = 0, lu_data = 0;
  logic stall, lu_ready, rf_regwr, sched_err;
  logic [4:0] rf_rw;
  logic [31:0] rf_busw, busy_mask;

  always #5 clk = ~clk;

  rf_wb_sched #(.LQ_DEPTH(LQ_DEPTH), .MAX_LONG(MAX_LONG)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .id_ra_i(id_ra), .id_rb_i(id_rb), .id_rw_i(id_rw),
    .id_wen_i(id_wen), .id_long_i(id_long), .stall_o(stall),
    .wb_valid_i(wb_valid), .wb_rw_i(wb_rw), .wb_data_i(wb_data),
    .lu_valid_i(lu_valid), .lu_rw_i(lu_rw), .lu_data_i(lu_data), .lu_ready_o(lu_ready),
    .rf_regwr_o(rf_regwr), .rf_rw_o(rf_rw), .rf_busw_o(rf_busw),
    .busy_mask_o(busy_mask), .sched_err_o(sched_err)
  );

  // Reference state: pending-register set, outstanding count, queued results, LU work in flight
  logic [31:0] m_busy = '0;
  int          m_count = 0;
  logic        m_err = 1'b0;
  logic [36:0] lq[$];
  logic [4:0]  infl[$];

  int n_total = 0, n_pass = 0, n_fail = 0;

`ifdef RF_SCHED_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_long = 0; id_wen = 0; id_ra = 0; id_rb = 0; id_rw = 0;
    wb_valid = 0; wb_rw = 0; wb_data = 0;
    lu_valid = 0; lu_rw = 0; lu_data = 0;
  endtask

  // Check one cycle against the model, then advance the model across the clock edge
  task automatic cycle();
    logic full, raw, waw, cap, acc, issue, commit, bypass;
    logic e_stall, e_ready, e_regwr;
    logic [4:0] e_rw;
    logic [31:0] e_busw;
    #1;
    full   = (lq.size() == LQ_DEPTH);
    raw    = (id_ra != 0 && m_busy[id_ra]) || (id_rb != 0 && m_busy[id_rb]);
    waw    = id_wen && id_rw != 0 && m_busy[id_rw];
    cap    = id_long && (m_count == MAX_LONG);
    e_stall = rst || (id_valid && (raw || waw || cap || full));
    e_ready = !full && !rst;
    acc     = lu_valid && e_ready;
    commit = 0; bypass = 0; e_regwr = 0; e_rw = 0; e_busw = 0;
    if (!rst) begin
      if (wb_valid) begin
        e_regwr = 1; e_rw = wb_rw; e_busw = wb_data;
      end else if (lq.size() != 0) begin
        e_regwr = 1; {e_rw, e_busw} = lq[0]; commit = 1;
      end else if (acc) begin
        e_regwr = 1; e_rw = lu_rw; e_busw = lu_data; commit = 1; bypass = 1;
      end
    end
    check("stall", 32'(stall), 32'(e_stall));
    check("lu_ready", 32'(lu_ready), 32'(e_ready));
    check("rf_regwr", 32'(rf_regwr), 32'(e_regwr));
    if (e_regwr) begin
      check("rf_rw", 32'(rf_rw), 32'(e_rw));
      check("rf_busw", rf_busw, e_busw);
    end
    check("busy_mask", busy_mask, m_busy);
    check("sched_err", 32'(sched_err), 32'(m_err));

    if (rst) begin
      m_busy = '0; m_count = 0; m_err = 0; lq.delete(); infl.delete();
    end else begin
      issue = id_valid && id_long && !e_stall;
`ifdef RF_SCHED_CHECK_EN
      if ((wb_valid && wb_rw != 0 && m_busy[wb_rw]) ||
          (acc && lu_rw != 0 && !m_busy[lu_rw]) || (acc && m_count == 0))
        m_err = 1;
`endif
      if (commit && !bypass) void'(lq.pop_front());
      if (acc && !bypass) lq.push_back({lu_rw, lu_data});
      if (acc) begin
        for (int i = 0; i < infl.size(); i++)
          if (infl[i] == lu_rw) begin infl.delete(i); break; end
      end
      if (commit) m_busy[e_rw] = 1'b0;
      if (issue && id_wen && id_rw != 0) m_busy[id_rw] = 1'b1;
      if (issue) infl.push_back(id_wen ? id_rw : 5'd0);
      m_count = m_count + int'(issue) - int'(commit);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue_long(input logic [4:0] rw);
    idle_inputs();
    id_valid = 1; id_long = 1; id_wen = 1; id_rw = rw;
    cycle();
  endtask

  task automatic lu_return(input logic [4:0] rw);
    idle_inputs();
    lu_valid = 1; lu_rw = rw; lu_data = $urandom;
    cycle();
  endtask

  initial begin
    @(negedge clk);
    idle_inputs();
    wb_valid = 1; wb_rw = 3; lu_valid = 1;
    #1;
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_lu_ready", 32'(lu_ready), 32'd0);
    check("rst_regwr", 32'(rf_regwr), 32'd0);
    cycle();
    idle_inputs();
    rst = 0;
    #1;
    check("idle_busy", busy_mask, 32'd0);
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_lu_ready", 32'(lu_ready), 32'd1);
    check("idle_regwr", 32'(rf_regwr), 32'd0);
    cycle();

    // RAW stall released by a same-cycle bypass commit
    issue_long(5);
    check("busy_r5", busy_mask, 32'h20);
    idle_inputs(); id_valid = 1; id_ra = 5;
    #1; check("raw_stall", 32'(stall), 32'd1);
    cycle();
    lu_valid = 1; lu_rw = 5; lu_data = 32'hDEADBEEF;
    #1;
    check("byp_regwr", 32'(rf_regwr), 32'd1);
    check("byp_rw", 32'(rf_rw), 32'd5);
    check("byp_data", rf_busw, 32'hDEADBEEF);
    cycle();
    lu_valid = 0;
    #1;
    check("byp_busy_clr", busy_mask, 32'd0);
    check("raw_release", 32'(stall), 32'd0);
    cycle();

    // WB wins the port, LU result queued then committed
    issue_long(7);
    idle_inputs();
    wb_valid = 1; wb_rw = 3; wb_data = 32'h33;
    lu_valid = 1; lu_rw = 7; lu_data = 32'h77;
    #1; check("wb_prio_rw", 32'(rf_rw), 32'd3);
    cycle();
    idle_inputs();
    #1;
    check("q_commit_rw", 32'(rf_rw), 32'd7);
    check("q_commit_data", rf_busw, 32'h77);
    cycle();
    check("r7_clr", busy_mask, 32'd0);

    // Fill the FIFO under sustained WB, then drain in order
    issue_long(10);
    issue_long(11);
    idle_inputs();
    wb_valid = 1; wb_rw = 1; wb_data = 32'h11;
    lu_valid = 1; lu_rw = 10; lu_data = 32'hA0;
    cycle();
    lu_rw = 11; lu_data = 32'hB0;
    cycle();
    lu_valid = 0; id_valid = 1; id_ra = 1; id_rw = 2; id_wen = 1;
    #1;
    check("full_lu_ready", 32'(lu_ready), 32'd0);
    check("full_stall", 32'(stall), 32'd1);
    cycle();
    idle_inputs();
    #1; check("drain0_rw", 32'(rf_rw), 32'd10);
    cycle();
    #1;
    check("drain1_rw", 32'(rf_rw), 32'd11);
    check("drain_lu_ready", 32'(lu_ready), 32'd1);
    cycle();
    check("drain_busy", busy_mask, 32'd0);

    // Outstanding-op cap
    for (int r = 12; r < 16; r++) issue_long(5'(r));
    idle_inputs(); id_valid = 1; id_long = 1; id_wen = 1; id_rw = 16;
    #1; check("cap_stall", 32'(stall), 32'd1);
    cycle();
    idle_inputs(); id_valid = 1; id_wen = 1; id_rw = 17; id_ra = 1;
    #1; check("cap_short_ok", 32'(stall), 32'd0);
    cycle();
    idle_inputs(); id_valid = 1; id_long = 1; id_wen = 1; id_rw = 16;
    lu_valid = 1; lu_rw = 12; lu_data = 32'hC12;
    #1; check("cap_commit_cycle", 32'(stall), 32'd1);
    cycle();
    lu_valid = 0;
    #1; check("cap_release", 32'(stall), 32'd0);
    cycle();
    for (int r = 13; r < 17; r++) lu_return(5'(r));
    check("cap_busy_clr", busy_mask, 32'd0);

    // Random legal traffic, with one mid-run reset
    for (int i = 0; i < 1500; i++) begin
      idle_inputs();
      rst = (i == 800);
      id_valid = ($urandom_range(0, 9) < 7);
      id_long  = ($urandom_range(0, 9) < 4);
      id_wen   = ($urandom_range(0, 9) < 8);
      id_ra = 5'($urandom_range(0, 15));
      id_rb = 5'($urandom_range(0, 15));
      id_rw = 5'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        wb_valid = 1;
        wb_rw = 5'($urandom_range(0, 31));
        if (m_busy[wb_rw]) wb_rw = 0;
        wb_data = $urandom;
      end
      if (infl.size() > 0 && $urandom_range(0, 1) == 1) begin
        lu_valid = 1;
        lu_rw = infl[$urandom_range(0, infl.size() - 1)];
        lu_data = $urandom;
      end
      cycle();
    end
    rst = 0;

    // Protocol checker: WB write into a pending register
    idle_inputs(); rst = 1; cycle(); rst = 0;
    issue_long(9);
    idle_inputs(); wb_valid = 1; wb_rw = 9; wb_data = 32'h99;
    cycle();
    check("err_set", 32'(sched_err), 32'(ERR_EXP));
    idle_inputs(); cycle(); cycle();
    check("err_sticky", 32'(sched_err), 32'(ERR_EXP));
    rst = 1; cycle(); rst = 0;
    check("err_rst", 32'(sched_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
